// File: rtl/gol_pkg.sv
// gol_pkg: board defaults, FSM states, goal-row mask and glider seed for the Game of Life stepper
package gol_pkg;
    localparam int DEF_WIDTH  = 10;
    localparam int DEF_HEIGHT = 9;
    localparam logic [15:0] GOAL_ROWS = 16'h01C7;
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
    function automatic logic [255:0] glider_seed(input int w);
        logic [255:0] s;
        s = '0;
        s[8'(6 * w + 6)] = 1'b1;
        s[8'(7 * w + 7)] = 1'b1;
        s[8'(8 * w + 5)] = 1'b1;
        s[8'(8 * w + 6)] = 1'b1;
        s[8'(8 * w + 7)] = 1'b1;
        return s;
    endfunction
endpackage

// File: rtl/gol_rule.sv
// gol_rule: next state of one cell from its eight neighbours and its own alive bit
module gol_rule (
    input  logic [7:0] i_nb,
    input  logic       i_alive,
    output logic       o_next
);
    logic [3:0] w_n;
    always_comb begin
        w_n = '0;
        for (int i = 0; i < 8; i++) w_n += 4'(i_nb[i]);
        o_next = (w_n == 4'd3) || (i_alive && w_n == 4'd2);
    end
endmodule

// File: rtl/gol_stepper.sv
// gol_stepper: serial generation scanner with shadow buffer, one-cycle commit and edge scoring
module gol_stepper
    import gol_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int TICK_CYCLES = 16777217
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_en,
    input  logic        step_req,
    input  logic        clear,
    input  logic        load_en,
    input  logic [3:0]  load_row,
    input  logic [3:0]  load_col,
    input  logic        load_val,
    input  logic [3:0]  rd_row,
    input  logic [3:0]  rd_col,
    output logic        rd_cell,
    output logic        busy,
    output logic        done,
    output logic [9:0]  l_score,
    output logic [9:0]  r_score,
    output logic [15:0] gen_count
);
    localparam int N  = WIDTH * HEIGHT;
    localparam int IW = $clog2(N);
    localparam int TW = $clog2(TICK_CYCLES + 1);

    state_t          r_state;
    logic [N-1:0]    r_board, r_shadow;
    logic [IW-1:0]   r_idx;
    logic [3:0]      r_row, r_col;
    logic            r_pending, r_done;
    logic [9:0]      r_l, r_r;
    logic [15:0]     r_gen;
    logic [TW-1:0]   r_tick;
    logic [7:0]      w_nb;
    logic            w_next, w_tick, w_req;
    logic [9:0]      w_l_add, w_r_add;
    int              w_r, w_c;

    function automatic logic in_range(input int r, input int c);
        return r >= 0 && r < HEIGHT && c >= 0 && c < WIDTH;
    endfunction

    // Off-board coordinates read as dead, which gives the no-wrap edge rule
    function automatic logic cell_at(input logic [N-1:0] b, input int r, input int c);
        return in_range(r, c) ? b[IW'(r * WIDTH + c)] : 1'b0;
    endfunction

    assign w_r = int'(r_row);
    assign w_c = int'(r_col);
    assign w_tick = run_en && r_tick == TW'(TICK_CYCLES - 1);
    assign w_req = step_req || w_tick;

    always_comb begin
        w_nb = {cell_at(r_board, w_r - 1, w_c - 1), cell_at(r_board, w_r - 1, w_c),
                cell_at(r_board, w_r - 1, w_c + 1), cell_at(r_board, w_r, w_c - 1),
                cell_at(r_board, w_r, w_c + 1),     cell_at(r_board, w_r + 1, w_c - 1),
                cell_at(r_board, w_r + 1, w_c),     cell_at(r_board, w_r + 1, w_c + 1)};
    end

    gol_rule u_rule (
        .i_nb    (w_nb),
        .i_alive (r_board[r_idx]),
        .o_next  (w_next)
    );

    // Column 0 feeds the right player, the last column the left player
    always_comb begin
        w_l_add = '0;
        w_r_add = '0;
        for (int r = 0; r < HEIGHT; r++)
            if (GOAL_ROWS[4'(r)]) begin
                w_r_add += 10'(r_shadow[IW'(r * WIDTH)]);
                w_l_add += 10'(r_shadow[IW'(r * WIDTH + WIDTH - 1)]);
            end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_board   <= N'(glider_seed(WIDTH));
            r_shadow  <= '0;
            r_idx     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            r_l       <= '0;
            r_r       <= '0;
            r_gen     <= '0;
            r_tick    <= '0;
        end else begin
            if (run_en) r_tick <= w_tick ? '0 : r_tick + 1'b1;
            if (r_state != IDLE && w_req) r_pending <= 1'b1;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req || r_pending) begin
                        r_state   <= SCAN;
                        r_pending <= 1'b0;
                        r_idx     <= '0;
                        r_row     <= '0;
                        r_col     <= '0;
                    end else if (clear) begin
                        r_board <= '0;
                        r_l     <= '0;
                        r_r     <= '0;
                    end else if (load_en && in_range(int'(load_row), int'(load_col))) begin
                        r_board[IW'(int'(load_row) * WIDTH + int'(load_col))] <= load_val;
                    end
                end
                SCAN: begin
                    r_shadow[r_idx] <= w_next;
                    r_idx <= r_idx + 1'b1;
                    r_col <= r_col == 4'(WIDTH - 1) ? '0 : r_col + 1'b1;
                    r_row <= r_col == 4'(WIDTH - 1) ? r_row + 1'b1 : r_row;
                    if (r_idx == IW'(N - 1)) r_state <= COMMIT;
                end
                COMMIT: begin
                    r_board <= r_shadow;
                    r_l     <= r_l + w_l_add;
                    r_r     <= r_r + w_r_add;
                    r_gen   <= r_gen + 1'b1;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_cell   = cell_at(r_board, int'(rd_row), int'(rd_col));
    assign busy      = r_state != IDLE;
    assign done      = r_done;
    assign l_score   = r_l;
    assign r_score   = r_r;
    assign gen_count = r_gen;
endmodule
